// File: rtl/apb_periph_bridge_if.sv
//------------------------------------------------------------------------------
// apb_periph_bridge_if : APB3 completer-side bus bundle for apb_periph_bridge
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface apb_periph_bridge_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

`default_nettype wire

// File: rtl/apb_periph_bridge.sv
//------------------------------------------------------------------------------
// apb_periph_bridge : APB3 to simple register-strobe bridge with error counting
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module apb_periph_bridge #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int RD_WAIT  = 1,
  parameter int NUM_REGS = 64
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb_periph_bridge_if.slave   apb,
  output logic [ADDR_W-1:0]    p_address,
  output logic [DATA_W-1:0]    p_data,
  output logic                 p_wr,
  output logic                 p_rd,
  input  logic [DATA_W-1:0]    p_data_back,
  output logic [7:0]           err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ACC  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_DONE = 3'd3,
    S_ERR_ACC = 3'd4
  } state_t;

  localparam logic [3:0] C_RD_WAIT = 4'(RD_WAIT);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [31:0]         prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [ADDR_W-1:0]   p_address_q, p_address_d;
  logic [DATA_W-1:0]   p_data_q, p_data_d;
  logic                p_wr_q, p_wr_d;
  logic                p_rd_q, p_rd_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic w_setup;
  logic w_access;
  logic w_illegal;

  assign w_setup   = apb.PSEL && !apb.PENABLE;
  assign w_access  = apb.PSEL && apb.PENABLE;
  // Upper address bits must be clear and the index must hit a decoded register
  assign w_illegal = ((apb.PADDR >> ADDR_W) != 32'd0) ||
                     (32'(apb.PADDR[ADDR_W-1:0]) >= 32'(NUM_REGS));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prdata_d    = prdata_q;
    pready_d    = pready_q;
    pslverr_d   = pslverr_q;
    p_address_d = p_address_q;
    p_data_d    = p_data_q;
    p_wr_d      = 1'b0;
    p_rd_d      = 1'b0;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (w_setup) begin
          p_address_d = apb.PADDR[ADDR_W-1:0];
          if (w_illegal) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = S_ERR_ACC;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (!apb.PWRITE) prdata_d = 32'd0;
          end else if (apb.PWRITE) begin
            p_data_d = apb.PWDATA[DATA_W-1:0];
            p_wr_d   = 1'b1;
            pready_d = 1'b1;
            state_d  = S_WR_ACC;
          end else begin
            p_rd_d  = 1'b1;
            cnt_d   = C_RD_WAIT;
            state_d = S_RD_WAIT;
          end
        end
      end

      S_RD_WAIT: begin
        if (!apb.PSEL) begin
          state_d   = S_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (w_access) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            prdata_d = 32'(p_data_back);
            pready_d = 1'b1;
            state_d  = S_RD_DONE;
          end
        end
      end

      default: begin
        // WR_ACC, RD_DONE and ERR_ACC all wait only for completion or abort
        if (!apb.PSEL || (w_access && pready_q)) begin
          state_d   = S_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      prdata_q    <= 32'd0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      p_address_q <= '0;
      p_data_q    <= '0;
      p_wr_q      <= 1'b0;
      p_rd_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      p_address_q <= p_address_d;
      p_data_q    <= p_data_d;
      p_wr_q      <= p_wr_d;
      p_rd_q      <= p_rd_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PRDATA  = prdata_q;
  assign apb.PSLVERR = pslverr_q;
  assign p_address   = p_address_q;
  assign p_data      = p_data_q;
  assign p_wr        = p_wr_q;
  assign p_rd        = p_rd_q;
  assign err_cnt     = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_periph_bridge.sv
//------------------------------------------------------------------------------
// tb_apb_periph_bridge : directed self-checking bench for apb_periph_bridge
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_periph_bridge;

  // NUM_REGS below 2^ADDR_W so the register-index bound is also exercised
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 16;
  localparam int RD_WAIT  = 3;
  localparam int NUM_REGS = 48;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [ADDR_W-1:0] p_address;
  logic [DATA_W-1:0] p_data;
  logic              p_wr;
  logic              p_rd;
  logic [DATA_W-1:0] p_data_back;
  logic [7:0]        err_cnt;

  apb_periph_bridge_if bus ();

  apb_periph_bridge #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_WAIT  (RD_WAIT),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .apb         (bus.slave),
    .p_address   (p_address),
    .p_data      (p_data),
    .p_wr        (p_wr),
    .p_rd        (p_rd),
    .p_data_back (p_data_back),
    .err_cnt     (err_cnt)
  );

  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_pdata  = 16'd0;
  logic [31:0] m_prdata = 32'd0;
  int          m_errcnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic go_idle();
    @(negedge PCLK);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    check("idle.pready",  bus.PREADY,  1'b0);
    check("idle.pslverr", bus.PSLVERR, 1'b0);
    check("idle.p_wr",    p_wr,        1'b0);
    check("idle.p_rd",    p_rd,        1'b0);
  endtask

  // Setup + access; returns with PREADY seen high, completion at the next edge
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [15:0] back, input logic exp_err, input int exp_cycles,
                          input string tag);
    int cyc;
    int nwr;
    int nrd;
    int bad;
    bit done;
    @(negedge PCLK);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR   = addr;
    bus.PWRITE  = wr;
    bus.PWDATA  = wdata;
    p_data_back = back;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    cyc = 0; nwr = 0; nrd = 0; bad = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (i > 0) @(negedge PCLK);
      cyc++;
      nwr += int'(p_wr);
      nrd += int'(p_rd);
      if (!bus.PREADY && bus.PSLVERR) bad++;
      if (bus.PREADY) done = 1'b1;
    end
    if (exp_err) begin
      if (m_errcnt < 255) m_errcnt++;
      if (!wr) m_prdata = 32'd0;
    end else if (wr) begin
      m_pdata = wdata[15:0];
    end else begin
      m_prdata = {16'd0, back};
    end
    check({tag, ".done"},    32'(done),     32'd1);
    check({tag, ".cycles"},  32'(cyc),      32'(exp_cycles));
    check({tag, ".pslverr"}, bus.PSLVERR,   exp_err);
    check({tag, ".addr"},    p_address,     addr[5:0]);
    check({tag, ".p_data"},  p_data,        m_pdata);
    check({tag, ".prdata"},  bus.PRDATA,    m_prdata);
    check({tag, ".err_cnt"}, err_cnt,       32'(m_errcnt));
    check({tag, ".n_wr"},    32'(nwr),      32'(wr && !exp_err));
    check({tag, ".n_rd"},    32'(nrd),      32'(!wr && !exp_err));
    check({tag, ".errnordy"}, 32'(bad),     32'd0);
  endtask

  initial begin
    bus.PADDR   = 32'd0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PWDATA  = 32'd0;
    p_data_back = 16'd0;

    repeat (2) @(negedge PCLK);
    check("rst.pready",  bus.PREADY,  1'b0);
    check("rst.pslverr", bus.PSLVERR, 1'b0);
    check("rst.prdata",  bus.PRDATA,  32'd0);
    check("rst.addr",    p_address,   6'd0);
    check("rst.p_data",  p_data,      16'd0);
    check("rst.p_wr",    p_wr,        1'b0);
    check("rst.p_rd",    p_rd,        1'b0);
    check("rst.err_cnt", err_cnt,     8'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Zero-wait write, then a 3-wait-state read (4 access cycles)
    apb_xfer(32'h05, 1'b1, 32'hABCD1234, 16'h0000, 1'b0, 1, "wr05");
    go_idle();
    apb_xfer(32'h07, 1'b0, 32'h0, 16'hBEEF, 1'b0, 4, "rd07");
    go_idle();

    // Access phase with no setup must be ignored
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 32'h03;
    @(negedge PCLK);
    check("nosetup.p_wr",   p_wr,       1'b0);
    check("nosetup.pready", bus.PREADY, 1'b0);
    check("nosetup.addr",   p_address,  6'd7);
    go_idle();

    // Illegal addresses: upper bits set, and index at NUM_REGS
    apb_xfer(32'h40, 1'b0, 32'h0, 16'h1111, 1'b1, 1, "rd40");
    go_idle();
    apb_xfer(32'h30, 1'b1, 32'h5555, 16'h0, 1'b1, 1, "wr30");
    go_idle();

    // Last legal index, then back-to-back write and read with no idle gap
    apb_xfer(32'h2F, 1'b0, 32'h0, 16'h1357, 1'b0, 4, "rd2f");
    apb_xfer(32'h0A, 1'b1, 32'h00009876, 16'h0, 1'b0, 1, "b2b.wr");
    apb_xfer(32'h0B, 1'b0, 32'h0, 16'h4242, 1'b0, 4, "b2b.rd");
    go_idle();

    // Abort during read wait states
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'h11;
    p_data_back = 16'h7777;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    check("abort.p_rd", p_rd, 1'b1);
    @(negedge PCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("abort.pready",  bus.PREADY,  1'b0);
      check("abort.pslverr", bus.PSLVERR, 1'b0);
      check("abort.p_rd",    p_rd,        1'b0);
      check("abort.prdata",  bus.PRDATA,  m_prdata);
    end
    apb_xfer(32'h12, 1'b1, 32'h0000C3C3, 16'h0, 1'b0, 1, "abort.wr");
    go_idle();

    // Error counter saturation
    for (int i = 0; i < 300; i++)
      apb_xfer(32'h1000 + 32'(i), 1'b1, 32'(i), 16'h0, 1'b1, 1, "ill");
    go_idle();
    check("sat.err_cnt", err_cnt, 8'd255);

    // Asynchronous reset in the middle of a read's wait states
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'h09;
    p_data_back = 16'hCAFE;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    #1;
    check("arst.pready",  bus.PREADY,  1'b0);
    check("arst.pslverr", bus.PSLVERR, 1'b0);
    check("arst.prdata",  bus.PRDATA,  32'd0);
    check("arst.addr",    p_address,   6'd0);
    check("arst.p_data",  p_data,      16'd0);
    check("arst.p_wr",    p_wr,        1'b0);
    check("arst.p_rd",    p_rd,        1'b0);
    check("arst.err_cnt", err_cnt,     8'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    m_pdata = 16'd0; m_prdata = 32'd0; m_errcnt = 0;
    apb_xfer(32'h05, 1'b1, 32'h0000FFFF, 16'h0, 1'b0, 1, "postrst.wr");
    go_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_periph_bridge.md
APB_PERIPH_BRIDGE -- requirements
Module: apb_periph_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 6: internal register address width (1..16).
REQ-002 SHALL have parameter DATA_W, default 16: internal data width (1..32).
REQ-003 SHALL have parameter RD_WAIT, default 1: read wait states inserted before read data is sampled (1..15).
REQ-004 SHALL have parameter NUM_REGS, default 64: number of decoded registers (1..2^ADDR_W).
REQ-005 SHALL have PCLK, input, 1: clock; all state changes on rising edge.
REQ-006 SHALL have PRESETn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have the APB3 inputs PADDR (32), PSEL (1), PENABLE (1), PWRITE (1) and PWDATA (32), with standard APB3 meaning.
REQ-008 SHALL have PREADY, output, 1: transfer complete.
REQ-009 SHALL have PRDATA, output, 32: read data, zero-extended from DATA_W.
REQ-010 SHALL have PSLVERR, output, 1: transfer error, valid only while PREADY=1.
REQ-011 SHALL have p_address, output, ADDR_W: latched register address.
REQ-012 SHALL have p_data, output, DATA_W: latched write data.
REQ-013 SHALL have p_wr, output, 1: one-cycle write strobe.
REQ-014 SHALL have p_rd, output, 1: one-cycle read strobe.
REQ-015 SHALL have p_data_back, input, DATA_W: register read data.
REQ-016 SHALL have err_cnt, output, 8: saturating count of errored transfers.

Function
REQ-017 SHALL implement FSM states IDLE, WR_ACC, RD_WAIT, RD_DONE and ERR_ACC, with all outputs registered.
REQ-018 SHALL treat an address as illegal when PADDR[31:ADDR_W] != 0 or PADDR[ADDR_W-1:0] >= NUM_REGS.
REQ-019 On a setup cycle in IDLE (PSEL=1, PENABLE=0), SHALL latch p_address <= PADDR[ADDR_W-1:0] regardless of address legality.
REQ-020 Legal write setup: SHALL latch p_data <= PWDATA[DATA_W-1:0], set p_wr<=1 and PREADY<=1, and go to WR_ACC (zero-wait write; p_wr high during the first access cycle).
REQ-021 Legal read setup: SHALL set p_rd<=1, load the wait counter with RD_WAIT, keep PREADY<=0, and go to RD_WAIT.
REQ-022 In RD_WAIT: SHALL decrement the counter each access edge; on the edge where the counter is 1, SHALL sample PRDATA <= {0, p_data_back}, set PREADY<=1, and go to RD_DONE.
REQ-023 Read access phase SHALL last exactly RD_WAIT+1 cycles.
REQ-024 Illegal setup (read or write): SHALL set PREADY<=1 and PSLVERR<=1, leave p_wr, p_rd and p_data untouched, and go to ERR_ACC.
REQ-025 In an errored read, PRDATA SHALL be forced to 0.
REQ-026 On every transition into ERR_ACC, err_cnt SHALL increment, saturating at 255.
REQ-027 p_wr and p_rd SHALL be single-cycle pulses; default 0 every cycle they are not set.
REQ-028 On completion (PSEL=1, PENABLE=1, PREADY=1 at an edge), SHALL return to IDLE and clear PREADY and PSLVERR.
REQ-029 PRDATA SHALL hold its value until the next read completes.
REQ-030 Back-to-back: a setup presented in the cycle immediately after completion SHALL be accepted with no idle gap.
REQ-031 Abort: PSEL=0 in any non-IDLE state SHALL force IDLE with PREADY=0 and PSLVERR=0, and SHALL issue no further strobes.
REQ-032 A p_rd already issued before an abort SHALL NOT be retracted.
REQ-033 In IDLE, access-phase inputs without a preceding setup (PENABLE=1) SHALL be ignored.
REQ-034 PSLVERR SHALL be 0 whenever PREADY=0.

Reset
REQ-035 PRESETn=0 SHALL immediately force IDLE and clear PRDATA, PREADY, PSLVERR, p_address, p_data, p_wr, p_rd, err_cnt and the wait counter to 0, including mid-transfer.
REQ-036 After release, the first edge with a setup cycle SHALL be handled normally.

Verification
REQ-037 Write with defaults: PADDR=0x05, PWDATA=0xABCD1234 -> first access cycle has PREADY=1, p_wr=1, p_address=5, p_data=0x1234, PSLVERR=0.
REQ-038 Read with RD_WAIT=3, p_data_back=0xBEEF -> p_rd pulses once; PREADY=1 in the 4th access cycle; PRDATA=0x0000BEEF.
REQ-039 Read of PADDR=0x40 (defaults) -> PREADY=1 and PSLVERR=1 in the first access cycle; PRDATA=0; no p_rd; err_cnt=1.
REQ-040 300 illegal writes -> err_cnt=255; p_wr never asserted.
REQ-041 Back-to-back write then read -> both complete correctly, with no lost strobe and no idle cycle.
REQ-042 PRESETn low during a read's RD_WAIT, then released -> all outputs 0; next write completes with zero wait.
